// File: rtl/decompressor_stream_if.sv
// Valid/ready stream bundle for decompressor_stream: compressed beats in, decoded lines out.
// The master modport is the environment side and the slave modport is the decompressor side.
interface decompressor_stream_if #(
    parameter int IN_W       = 64,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 4
);
    logic                         i_valid;
    logic                         o_ready;
    logic [IN_W-1:0]              i_data;
    logic                         i_last;
    logic                         i_raw;
    logic                         o_valid;
    logic                         i_ready;
    logic [LINE_WORDS*WORD_W-1:0] o_data;
    logic                         o_err;

    modport master (
        output i_valid, i_data, i_last, i_raw, i_ready,
        input  o_ready, o_valid, o_data, o_err
    );

    modport slave (
        input  i_valid, i_data, i_last, i_raw, i_ready,
        output o_ready, o_valid, o_data, o_err
    );
endinterface

// File: rtl/decompressor_stream.sv
// Streaming dictionary decompressor: decodes one word per cycle from a bit buffer and
// assembles LINE_WORDS words into a line returned over a valid/ready output.
module decompressor_stream #(
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int DICT_DEPTH = 16,
    parameter int IN_W       = 64,
    parameter int PART_BITS  = 8,
    parameter int DICT_CLR   = 1
) (
    input logic                   i_clk,
    input logic                   i_reset,
    decompressor_stream_if.slave  bus
);
    localparam int IDX_W  = $clog2(DICT_DEPTH);
    localparam int BUF_W  = IN_W + WORD_W + 2;
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam int CNT_W  = $clog2(LINE_WORDS + 1);
    localparam int LINE_W = LINE_WORDS * WORD_W;

    localparam logic [FILL_W-1:0] LEN_ZERO = FILL_W'(2);
    localparam logic [FILL_W-1:0] LEN_LIT  = FILL_W'(2 + WORD_W);
    localparam logic [FILL_W-1:0] LEN_FULL = FILL_W'(2 + IDX_W);
    localparam logic [FILL_W-1:0] LEN_PART = FILL_W'(2 + IDX_W + PART_BITS);
    localparam logic [FILL_W-1:0] LEN_RAW  = FILL_W'(WORD_W);
    localparam logic [FILL_W-1:0] FILL_ACC = FILL_W'(BUF_W - IN_W);
    localparam logic [FILL_W-1:0] FILL_IN  = FILL_W'(IN_W);

    typedef enum logic [1:0] {S_DEC = 2'd0, S_DRAIN = 2'd1, S_OUT = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [BUF_W-1:0]    buf_q, buf_d, buf_sh_s;
    logic [FILL_W-1:0]   fill_q, fill_d, fill_sh_s;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                err_q, err_d, valid_q, valid_d;
    logic                raw_q, raw_d, first_q, first_d, last_q, last_d;
    logic [IDX_W-1:0]    wp_q, wp_d, idx_s;
    logic [WORD_W-1:0]   dict_q [DICT_DEPTH];
    logic [WORD_W-1:0]   dict_d [DICT_DEPTH];
    logic [WORD_W-1:0]   dict_word_s, word_s;
    logic [FILL_W-1:0]   len_s;
    logic                push_s, ready_s, accept_s, dec_s;

    // Symbol decode of the buffer head: word value, symbol length and dictionary push.
    always_comb begin
        idx_s       = buf_q[2 +: IDX_W];
        dict_word_s = dict_q[idx_s];
        word_s      = '0;
        len_s       = LEN_ZERO;
        push_s      = 1'b0;
        if (raw_q) begin
            word_s = buf_q[WORD_W-1:0];
            len_s  = LEN_RAW;
        end else begin
            case (buf_q[1:0])
                2'b00: begin word_s = '0; len_s = LEN_ZERO; end
                2'b01: begin word_s = buf_q[2 +: WORD_W]; len_s = LEN_LIT; push_s = 1'b1; end
                2'b10: begin word_s = dict_word_s; len_s = LEN_FULL; end
                2'b11: begin
                    word_s = {dict_word_s[WORD_W-1:PART_BITS], buf_q[2+IDX_W +: PART_BITS]};
                    len_s  = LEN_PART;
                    push_s = 1'b1;
                end
                default: begin word_s = '0; len_s = LEN_ZERO; end
            endcase
        end
    end

    // Next-state logic: beat acceptance, buffer shifting, line assembly and line hand-off.
    always_comb begin
        state_d = state_q; buf_d = buf_q; fill_d = fill_q; cnt_d = cnt_q;
        line_d = line_q; err_d = err_q; valid_d = valid_q; raw_d = raw_q;
        first_d = first_q; last_d = last_q; wp_d = wp_q; dict_d = dict_q;
        case (state_q)
            S_DEC:   ready_s = !last_q && (fill_q <= FILL_ACC);
            S_DRAIN: ready_s = 1'b1;
            S_OUT:   ready_s = 1'b0;
            default: ready_s = 1'b0;
        endcase
        accept_s = bus.i_valid && ready_s;
        dec_s    = (state_q == S_DEC) && (cnt_q < CNT_W'(LINE_WORDS)) && (fill_q >= len_s);
        if (dec_s) begin
            buf_sh_s  = buf_q >> len_s;
            fill_sh_s = fill_q - len_s;
        end else begin
            buf_sh_s  = buf_q;
            fill_sh_s = fill_q;
        end
        case (state_q)
            S_DEC: begin
                if (accept_s) begin
                    buf_d  = buf_sh_s | (BUF_W'(bus.i_data) << fill_sh_s);
                    fill_d = fill_sh_s + FILL_IN;
                    last_d = bus.i_last;
                    if (first_q) begin
                        raw_d   = bus.i_raw;
                        first_d = 1'b0;
                    end else begin
                        raw_d = raw_q;
                    end
                end else begin
                    buf_d  = buf_sh_s;
                    fill_d = fill_sh_s;
                end
                if (dec_s) begin
                    line_d[int'(cnt_q)*WORD_W +: WORD_W] = word_s;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (push_s) begin
                        dict_d[wp_q] = word_s;
                        wp_d         = wp_q + IDX_W'(1);
                    end else begin
                        wp_d = wp_q;
                    end
                    // Line complete: whatever is still buffered is padding.
                    if (cnt_q == CNT_W'(LINE_WORDS - 1)) begin
                        fill_d = '0;
                        if (last_q || (accept_s && bus.i_last)) begin
                            state_d = S_OUT;
                            valid_d = 1'b1;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        state_d = S_DEC;
                    end
                end else if (last_q) begin
                    // Stream ended mid-line; untouched words of the line are already zero.
                    state_d = S_OUT;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                    fill_d  = '0;
                end else begin
                    state_d = S_DEC;
                end
            end
            S_DRAIN: begin
                if (accept_s && bus.i_last) begin
                    state_d = S_OUT;
                    valid_d = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_OUT: begin
                if (bus.i_ready) begin
                    state_d = S_DEC; valid_d = 1'b0; err_d = 1'b0; line_d = '0;
                    cnt_d = '0; first_d = 1'b1; last_d = 1'b0; fill_d = '0; buf_d = '0;
                    if (DICT_CLR != 0) begin
                        dict_d = '{default: '0};
                        wp_d   = '0;
                    end else begin
                        wp_d = wp_q;
                    end
                end else begin
                    state_d = S_OUT;
                end
            end
            default: state_d = S_DEC;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_DEC;  buf_q <= '0;     fill_q <= '0;   cnt_q <= '0;
            line_q  <= '0;     err_q <= 1'b0;   valid_q <= 1'b0; raw_q <= 1'b0;
            first_q <= 1'b1;   last_q <= 1'b0;  wp_q <= '0;     dict_q <= '{default: '0};
        end else begin
            state_q <= state_d; buf_q <= buf_d;   fill_q <= fill_d;   cnt_q <= cnt_d;
            line_q  <= line_d;  err_q <= err_d;   valid_q <= valid_d; raw_q <= raw_d;
            first_q <= first_d; last_q <= last_d; wp_q <= wp_d;       dict_q <= dict_d;
        end
    end

    assign bus.o_ready = ready_s;
    assign bus.o_valid = valid_q;
    assign bus.o_data  = line_q;
    assign bus.o_err   = err_q;
endmodule

// File: tb/tb_decompressor_stream.sv
// Scoreboard bench: two decompressors (dictionary cleared per line / persistent) share one
// stimulus stream; expected lines are queued per instance and checked by independent monitors.
module tb_decompressor_stream;
    localparam int IN_W = 64, WORD_W = 32, LW = 4, LINE_W = LW * WORD_W;

    typedef struct packed { logic [LINE_W-1:0] data; logic err; } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0, acc_cyc = 0, n_vec = 0, n_bad = 0;
    exp_t q_c[$], q_k[$];
    exp_t e_c, e_k;
    logic [255:0] sacc;
    int   spos;

    decompressor_stream_if #(.IN_W(IN_W), .WORD_W(WORD_W), .LINE_WORDS(LW)) bus_c ();
    decompressor_stream_if #(.IN_W(IN_W), .WORD_W(WORD_W), .LINE_WORDS(LW)) bus_k ();

    decompressor_stream #(.DICT_CLR(1)) u_clr  (.i_clk(clk), .i_reset(rst), .bus(bus_c));
    decompressor_stream #(.DICT_CLR(0)) u_keep (.i_clk(clk), .i_reset(rst), .bus(bus_k));

    assign bus_k.i_valid = bus_c.i_valid;
    assign bus_k.i_data  = bus_c.i_data;
    assign bus_k.i_last  = bus_c.i_last;
    assign bus_k.i_raw   = bus_c.i_raw;
    assign bus_k.i_ready = bus_c.i_ready;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Monitor for the per-line-clear instance.
    always @(negedge clk) begin
        if (!rst && bus_c.o_valid && bus_c.i_ready) begin
            n_vec++;
            if (q_c.size() == 0) begin
                n_bad++;
                $display("FAIL line_clr: unexpected line %h err %b", bus_c.o_data, bus_c.o_err);
            end else begin
                e_c = q_c.pop_front();
                if ({bus_c.o_data, bus_c.o_err} !== {e_c.data, e_c.err}) begin
                    n_bad++;
                    $display("FAIL line_clr: got %h err %b want %h err %b", bus_c.o_data, bus_c.o_err, e_c.data, e_c.err);
                end
            end
        end
    end

    // Monitor for the persistent-dictionary instance.
    always @(negedge clk) begin
        if (!rst && bus_k.o_valid && bus_k.i_ready) begin
            n_vec++;
            if (q_k.size() == 0) begin
                n_bad++;
                $display("FAIL line_keep: unexpected line %h err %b", bus_k.o_data, bus_k.o_err);
            end else begin
                e_k = q_k.pop_front();
                if ({bus_k.o_data, bus_k.o_err} !== {e_k.data, e_k.err}) begin
                    n_bad++;
                    $display("FAIL line_keep: got %h err %b want %h err %b", bus_k.o_data, bus_k.o_err, e_k.data, e_k.err);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_line(input logic [LINE_W-1:0] dc, input logic [LINE_W-1:0] dk, input logic err);
        q_c.push_back('{data: dc, err: err});
        q_k.push_back('{data: dk, err: err});
    endtask

    task automatic sclear();
        sacc = '0;
        spos = 0;
    endtask

    task automatic sput(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) sacc[spos + i] = v[i];
        spos += n;
    endtask

    task automatic sym_zero();                                   sput(64'(2'b00), 2); endtask
    task automatic sym_lit(input logic [31:0] v);                sput(64'(2'b01), 2); sput(64'(v), 32); endtask
    task automatic sym_full(input logic [3:0] idx);              sput(64'(2'b10), 2); sput(64'(idx), 4); endtask
    task automatic sym_part(input logic [3:0] idx, input logic [7:0] lit);
        sput(64'(2'b11), 2); sput(64'(idx), 4); sput(64'(lit), 8);
    endtask

    task automatic send(input logic [63:0] d, input logic last, input logic raw);
        int t = 0;
        bus_c.i_valid = 1'b1; bus_c.i_data = d; bus_c.i_last = last; bus_c.i_raw = raw;
        while (!bus_c.o_ready && t < 200) begin tick(); t++; end
        if (!bus_c.o_ready) begin
            n_vec++; n_bad++;
            $display("FAIL send_timeout: o_ready stayed 0 for %0d cycles", t);
        end
        acc_cyc = cyc;
        tick();
        bus_c.i_valid = 1'b0; bus_c.i_last = 1'b0; bus_c.i_raw = 1'b0;
    endtask

    task automatic send_stream(input int nbeats, input logic raw);
        for (int b = 0; b < nbeats; b++) send(sacc[b*64 +: 64], b == nbeats - 1, raw && (b == 0));
    endtask

    task automatic wait_valid(input string name);
        int t = 0;
        while (!bus_c.o_valid && t < 100) begin tick(); t++; end
        chk(name, 128'(bus_c.o_valid), 128'(1'b1));
    endtask

    task automatic drain_wait(input string name);
        int t = 0;
        while ((q_c.size() != 0 || q_k.size() != 0) && t < 300) begin tick(); t++; end
        chk(name, 128'(q_c.size() + q_k.size()), 128'(0));
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk(name, 128'({bus_c.o_valid, bus_k.o_valid, bus_c.o_ready, bus_k.o_ready}), 128'(4'b0011));
    endtask

    initial begin
        rst = 1'b1; bus_c.i_valid = 1'b0; bus_c.i_data = '0; bus_c.i_last = 1'b0;
        bus_c.i_raw = 1'b0; bus_c.i_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("reset_ctl", 128'({bus_c.o_valid, bus_c.o_ready, bus_c.o_err, bus_k.o_valid, bus_k.o_ready, bus_k.o_err}), 128'(6'b010010));
        chk("reset_data_clr", bus_c.o_data, '0);
        chk("reset_data_keep", bus_k.o_data, '0);

        // Mixed symbols in a single beat, with minimum latency.
        sclear(); sym_lit(32'hDEADBEEF); sym_full(4'd0); sym_zero(); sym_part(4'd0, 8'h12);
        expect_line({32'hDEADBE12, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF},
                    {32'hDEADBE12, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF}, 1'b0);
        send_stream(1, 1'b0);
        begin
            int t = 0;
            while (!bus_c.o_valid && t < 50) begin tick(); t++; end
        end
        chk("latency", 128'(cyc - acc_cyc), 128'(5));
        drain_wait("single_beat_done");

        // Raw line over two beats, then prove the raw words were not pushed.
        sclear(); sput(64'h22222222_11111111, 64); sput(64'h44444444_33333333, 64);
        expect_line({32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                    {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 1'b0);
        send_stream(2, 1'b1);
        drain_wait("raw_done");
        sclear(); sym_full(4'd0); sym_full(4'd1); sym_full(4'd2); sym_zero();
        expect_line('0, {32'h0, 32'h0, 32'hDEADBE12, 32'hDEADBEEF}, 1'b0);
        send_stream(1, 1'b0);
        drain_wait("dict_after_raw_done");

        // Dictionary wrap: 20 literal pushes into 16 entries.
        do_reset("reset_before_wrap");
        for (int l = 0; l < 5; l++) begin
            sclear();
            for (int w = 0; w < 4; w++) sym_lit(32'(l * 4 + w + 1));
            expect_line({32'(l*4+4), 32'(l*4+3), 32'(l*4+2), 32'(l*4+1)},
                        {32'(l*4+4), 32'(l*4+3), 32'(l*4+2), 32'(l*4+1)}, 1'b0);
            send_stream(3, 1'b0);
        end
        sclear(); sym_full(4'd0); sym_full(4'd1); sym_full(4'd15); sym_full(4'd4);
        expect_line('0, {32'd5, 32'd16, 32'd18, 32'd17}, 1'b0);
        send_stream(1, 1'b0);
        drain_wait("wrap_done");

        // Backpressure with padding beats drained after the line completes.
        bus_c.i_ready = 1'b0;
        sclear(); sym_lit(32'h0BADF00D); sym_part(4'd0, 8'h77); sym_zero(); sym_full(4'd1);
        expect_line({32'h0BADF077, 32'h0, 32'h0BADF077, 32'h0BADF00D},
                    {32'h00000012, 32'h0, 32'h00000077, 32'h0BADF00D}, 1'b0);
        send(sacc[63:0], 1'b0, 1'b0);
        send(64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0);
        send(64'hA5A5A5A5_A5A5A5A5, 1'b0, 1'b0);
        send(64'h01234567_89ABCDEF, 1'b1, 1'b0);
        wait_valid("bp_valid");
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_ctl", 128'({bus_c.o_valid, bus_c.o_ready, bus_k.o_valid, bus_k.o_ready}), 128'(4'b1010));
            chk("bp_hold_clr", bus_c.o_data, {32'h0BADF077, 32'h0, 32'h0BADF077, 32'h0BADF00D});
            tick();
        end
        bus_c.i_ready = 1'b1;
        drain_wait("bp_done");

        // Truncated lines: compressed with a cut-off literal, and raw with one beat.
        sclear(); sym_zero(); sym_zero(); sym_lit(32'h0); sput(64'(2'b01), 2);
        expect_line('0, '0, 1'b1);
        send_stream(1, 1'b0);
        drain_wait("trunc_done");
        sclear(); sput(64'h87654321_CAFEF00D, 64);
        expect_line({32'h0, 32'h0, 32'h87654321, 32'hCAFEF00D},
                    {32'h0, 32'h0, 32'h87654321, 32'hCAFEF00D}, 1'b1);
        send_stream(1, 1'b1);
        drain_wait("raw_trunc_done");

        // Reset while draining, then a fresh line must see an empty dictionary.
        sclear(); sym_lit(32'h5A5A5A5A); sym_zero(); sym_zero(); sym_zero();
        send(sacc[63:0], 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        chk("in_drain", 128'({bus_c.o_valid, bus_c.o_ready}), 128'(2'b01));
        do_reset("reset_in_drain");
        sclear(); sym_full(4'd0); sym_full(4'd1); sym_zero(); sym_zero();
        expect_line('0, '0, 1'b0);
        send_stream(1, 1'b0);
        drain_wait("after_drain_reset_done");

        // Reset while a line waits in the output stage.
        bus_c.i_ready = 1'b0;
        sclear(); sym_lit(32'h77777777); sym_zero(); sym_zero(); sym_zero();
        send_stream(1, 1'b0);
        wait_valid("out_before_reset");
        do_reset("reset_in_out");
        bus_c.i_ready = 1'b1;
        sclear(); sym_full(4'd0); sym_full(4'd1); sym_zero(); sym_zero();
        expect_line('0, '0, 1'b0);
        send_stream(1, 1'b0);
        drain_wait("after_out_reset_done");

        for (int i = 0; i < 5; i++) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
